// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the memory port arbiter
// Purpose: FSM state encoding, transaction owner encoding, default parameters.
// Ports: none (package).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/arb_lat_counter.sv
// rtl/arb_lat_counter.sv - memory latency down-counter
// Purpose: loads MEM_LAT-1 on a grant, counts down while waiting, flags zero.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (count -> 0)
//   load        - load MEM_LAT-1 this cycle
//   dec         - decrement this cycle (holds at 0)
//   zero        - count equals 0
module arb_lat_counter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int CW      = $clog2(MEM_LAT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM shared memory port arbiter
// Purpose: grants one of fetch (IF) or data (DM) requesters per transaction,
//   sequences a fixed-latency memory access and returns data with a one-cycle
//   rvalid pulse. DM has priority; IF wins after STARVE_MAX lost contests.
// Ports:
//   clk, reset                        - clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt          - fetch request and same-cycle grant
//   if_rvalid/if_rdata                - fetch response pulse and data
//   dm_req/dm_we/dm_addr/dm_wdata     - data request (read or write)
//   dm_gnt, dm_rvalid/dm_rdata        - data grant and completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata  - memory strobe and command
//   mem_rdata                         - memory data, MEM_LAT cycles after mem_en
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int            SW       = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_V = SW'(STARVE_MAX);

  arb_state_t        state, next_state;
  arb_owner_t        owner;
  logic              owner_we;
  logic [DATA_W-1:0] resp_data;
  logic [SW-1:0]     starve_cnt;
  logic              lat_zero;

  logic arb_ok, dm_wins, grant_dm, grant_if, any_grant, resp_live;

  // Arbitration is open in IDLE and RESP; reset closes it so nothing is granted.
  assign arb_ok    = !reset && ((state == ARB_IDLE) || (state == ARB_RESP));
  assign dm_wins   = dm_req && (!if_req || (starve_cnt != STARVE_V));
  assign grant_dm  = arb_ok && dm_wins;
  assign grant_if  = arb_ok && if_req && !dm_wins;
  assign any_grant = grant_dm || grant_if;
  assign resp_live = !reset && (state == ARB_RESP);

  arb_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
    .clk   (clk),
    .reset (reset),
    .load  (any_grant),
    .dec   (state == ARB_WAIT),
    .zero  (lat_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE: next_state = any_grant ? ARB_WAIT : ARB_IDLE;
      ARB_WAIT: next_state = lat_zero ? ARB_RESP : ARB_WAIT;
      ARB_RESP: next_state = any_grant ? ARB_WAIT : ARB_IDLE;
      default:  next_state = ARB_IDLE;
    endcase
  end

  // Owner, write flag, captured data and starvation count.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= OWN_IF;
      owner_we   <= 1'b0;
      resp_data  <= '0;
      starve_cnt <= '0;
    end else begin
      if (any_grant) begin
        owner    <= grant_dm ? OWN_DM : OWN_IF;
        owner_we <= grant_dm && dm_we;
      end
      if ((state == ARB_WAIT) && lat_zero) begin
        resp_data <= mem_rdata;
      end
      if (arb_ok) begin
        if (!if_req || grant_if) begin
          starve_cnt <= '0;
        end else if (grant_dm && (starve_cnt != STARVE_V)) begin
          starve_cnt <= starve_cnt + SW'(1);
        end
      end
    end
  end

  always_comb begin
    if_gnt    = grant_if;
    dm_gnt    = grant_dm;
    mem_en    = any_grant;
    mem_we    = grant_dm && dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_dm) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (grant_if) begin
      mem_addr  = if_addr;
    end
    if_rvalid = resp_live && (owner == OWN_IF);
    dm_rvalid = resp_live && (owner == OWN_DM);
    if_rdata  = if_rvalid ? resp_data : '0;
    dm_rdata  = (dm_rvalid && !owner_we) ? resp_data : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr;
  logic [15:0] dm_wdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we;
  logic [15:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic [31:0] mem_addr;
  logic [15:0] pipe1, pipe2;

  int checks = 0;
  int failures = 0;
  int n_if_rv = 0;
  int n_dm_rv = 0;
  int snap;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(16), .MEM_LAT(2), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: read data a+0x100, visible two cycles after mem_en.
  always @(posedge clk) begin
    pipe1 <= mem_en ? (mem_addr[15:0] + 16'h0100) : 16'hDEAD;
    pipe2 <= pipe1;
  end
  assign mem_rdata = pipe2;

  always @(negedge clk) begin
    if (if_rvalid) n_if_rv = n_if_rv + 1;
    if (dm_rvalid) n_dm_rv = n_dm_rv + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0;
    cyc();
    if_req = 1; dm_req = 1;
    settle();
    check("rst_if_gnt", 32'(if_gnt), 0);
    check("rst_dm_gnt", 32'(dm_gnt), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rvalid", 32'({if_rvalid, dm_rvalid}), 0);
    cyc();
    reset = 0; if_req = 0; dm_req = 0;
    cyc();

    // Single fetch
    snap = n_dm_rv;
    if_req = 1; if_addr = 32'h20;
    settle();
    check("fetch_gnt", 32'(if_gnt), 1);
    check("fetch_mem_en", 32'(mem_en), 1);
    check("fetch_mem_we", 32'(mem_we), 0);
    check("fetch_mem_addr", mem_addr, 32'h20);
    cyc(); if_req = 0; settle();
    check("fetch_t1_rv", 32'(if_rvalid), 0);
    check("fetch_t1_en", 32'(mem_en), 0);
    cyc(); settle();
    check("fetch_t2_rv", 32'(if_rvalid), 0);
    cyc(); settle();
    check("fetch_t3_rv", 32'(if_rvalid), 1);
    check("fetch_t3_data", 32'(if_rdata), 32'h0120);
    cyc(); settle();
    check("fetch_t4_rv", 32'(if_rvalid), 0);
    check("fetch_no_dm_rv", n_dm_rv, snap);

    // Contention: DM wins, IF granted in the DM response cycle
    if_req = 1; if_addr = 32'h30; dm_req = 1; dm_we = 0; dm_addr = 32'h05;
    settle();
    check("cont_dm_gnt", 32'(dm_gnt), 1);
    check("cont_if_gnt", 32'(if_gnt), 0);
    check("cont_mem_addr", mem_addr, 32'h05);
    cyc(); dm_req = 0; settle();
    check("cont_wait_gnt", 32'(if_gnt), 0);
    cyc(); cyc(); settle();
    check("cont_dm_rv", 32'(dm_rvalid), 1);
    check("cont_dm_data", 32'(dm_rdata), 32'h0105);
    check("cont_if_gnt3", 32'(if_gnt), 1);
    check("cont_if_addr", mem_addr, 32'h30);
    cyc(); if_req = 0; cyc(); cyc(); settle();
    check("cont_if_rv", 32'(if_rvalid), 1);
    check("cont_if_data", 32'(if_rdata), 32'h0130);
    cyc();

    // Write
    dm_req = 1; dm_we = 1; dm_addr = 32'h10; dm_wdata = 16'hFFF2;
    settle();
    check("wr_gnt", 32'(dm_gnt), 1);
    check("wr_en_we", 32'({mem_en, mem_we}), 3);
    check("wr_addr", mem_addr, 32'h10);
    check("wr_wdata", 32'(mem_wdata), 32'hFFF2);
    cyc(); dm_req = 0; dm_we = 0; settle();
    check("wr_en_off", 32'({mem_en, mem_we}), 0);
    cyc(); cyc(); settle();
    check("wr_rv", 32'(dm_rvalid), 1);
    check("wr_rdata", 32'(dm_rdata), 0);
    cyc();

    // Starvation: 4 DM grants, then IF, then DM again
    if_req = 1; if_addr = 32'h40; dm_req = 1; dm_we = 0; dm_addr = 32'h08;
    for (int g = 0; g < 6; g++) begin
      settle();
      check("starve_dm_gnt", 32'(dm_gnt), (g == 4) ? 0 : 1);
      check("starve_if_gnt", 32'(if_gnt), (g == 4) ? 1 : 0);
      cyc();
      if (g == 4) check("starve_cnt_clr", 32'(dut.starve_cnt), 0);
      if (g == 5) begin if_req = 0; dm_req = 0; end
      cyc(); cyc();
    end
    cyc();

    // Reset mid-transaction
    snap = n_dm_rv;
    dm_req = 1; dm_we = 0; dm_addr = 32'h07;
    settle();
    check("rm_dm_gnt", 32'(dm_gnt), 1);
    cyc(); reset = 1; if_req = 1; settle();
    check("rm_rst_gnt", 32'({if_gnt, dm_gnt}), 0);
    check("rm_rst_en", 32'(mem_en), 0);
    cyc(); reset = 0; if_req = 0; dm_req = 0;
    cyc(); if_req = 1; if_addr = 32'h50; settle();
    check("rm_if_gnt", 32'(if_gnt), 1);
    check("rm_no_dm_rv_t3", 32'(dm_rvalid), 0);
    cyc(); if_req = 0; cyc(); cyc(); settle();
    check("rm_if_rv", 32'(if_rvalid), 1);
    check("rm_if_data", 32'(if_rdata), 32'h0150);
    cyc(); cyc();
    check("rm_no_dm_rv", n_dm_rv, snap);

    // Back-to-back DM reads
    dm_req = 1; dm_we = 0; dm_addr = 32'h0A;
    settle();
    check("b2b_gnt0", 32'(dm_gnt), 1);
    cyc(); dm_addr = 32'h0B; cyc(); cyc(); settle();
    check("b2b_rv1", 32'(dm_rvalid), 1);
    check("b2b_data1", 32'(dm_rdata), 32'h010A);
    check("b2b_gnt1", 32'(dm_gnt), 1);
    check("b2b_addr1", mem_addr, 32'h0B);
    cyc(); dm_addr = 32'h0C; cyc(); cyc(); settle();
    check("b2b_rv2", 32'(dm_rvalid), 1);
    check("b2b_data2", 32'(dm_rdata), 32'h010B);
    check("b2b_gnt2", 32'(dm_gnt), 1);
    cyc(); dm_req = 0; cyc(); cyc(); settle();
    check("b2b_rv3", 32'(dm_rvalid), 1);
    check("b2b_data3", 32'(dm_rdata), 32'h010C);
    check("b2b_no_gnt", 32'(dm_gnt), 0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
